// File: rtl/interrupt_pkg.sv
// Shared state encoding and constants for the interrupt entry/return sequencer.
package interrupt_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_DRAIN   = 4'd1;
  localparam logic [3:0] ST_PUSH_HI = 4'd2;
  localparam logic [3:0] ST_PUSH_LO = 4'd3;
  localparam logic [3:0] ST_PUSH_FL = 4'd4;
  localparam logic [3:0] ST_VEC_HI  = 4'd5;
  localparam logic [3:0] ST_VEC_LO  = 4'd6;
  localparam logic [3:0] ST_JUMP    = 4'd7;
  localparam logic [3:0] ST_POP_FL  = 4'd8;
  localparam logic [3:0] ST_POP_LO  = 4'd9;
  localparam logic [3:0] ST_POP_HI  = 4'd10;
  localparam logic [3:0] ST_RET     = 4'd11;

  localparam int PUSH_WORDS    = 3;
  localparam int VEC_ADDR_DFLT = 0;

  function automatic logic is_mem_state(logic [3:0] st);
    return st inside {ST_PUSH_HI, ST_PUSH_LO, ST_PUSH_FL, ST_VEC_HI, ST_VEC_LO,
                      ST_POP_FL, ST_POP_LO, ST_POP_HI};
  endfunction

  function automatic logic is_pop_state(logic [3:0] st);
    return st inside {ST_POP_FL, ST_POP_LO, ST_POP_HI, ST_RET};
  endfunction

endpackage

// File: rtl/interrupt_service_controller_if.sv
// Data-memory port between the interrupt sequencer (master) and the port arbiter (slave).
interface interrupt_service_controller_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/interrupt_stack_addr.sv
// Combinational stack/vector address generator: word address per memory state and final SP.
module interrupt_stack_addr
  import interrupt_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] VEC_ADDR = '0
) (
  input  logic [ADDR_W-1:0] s_i,
  input  logic [3:0]        state_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] sp_o
);

  // All arithmetic wraps naturally at ADDR_W bits.
  always_comb begin
    addr_o = '0;
    case (state_i)
      ST_PUSH_HI: addr_o = s_i;
      ST_PUSH_LO: addr_o = s_i - ADDR_W'(1);
      ST_PUSH_FL: addr_o = s_i - ADDR_W'(2);
      ST_VEC_HI:  addr_o = VEC_ADDR;
      ST_VEC_LO:  addr_o = VEC_ADDR + ADDR_W'(1);
      ST_POP_FL:  addr_o = s_i + ADDR_W'(1);
      ST_POP_LO:  addr_o = s_i + ADDR_W'(2);
      ST_POP_HI:  addr_o = s_i + ADDR_W'(3);
      default:    addr_o = '0;
    endcase
  end

  assign sp_o = pop_i ? s_i + ADDR_W'(PUSH_WORDS) : s_i - ADDR_W'(PUSH_WORDS);

endmodule

// File: rtl/interrupt_service_controller.sv
// Sequences interrupt entry (drain, push PC/flags, fetch vector, jump) and RTI (pop flags/PC, return).
// Outputs decode registered state only; each memory state holds its request until mem_ack.
module interrupt_service_controller
  import interrupt_pkg::*;
#(
  parameter int                PC_W      = 32,
  parameter int                ADDR_W    = 32,
  parameter int                FLAG_W    = 4,
  parameter logic [ADDR_W-1:0] VEC_ADDR  = ADDR_W'(VEC_ADDR_DFLT),
  parameter int                DRAIN_CYC = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           intr_req,
  input  logic                           rti_req,
  input  logic [PC_W-1:0]                pc_in,
  input  logic [FLAG_W-1:0]              flags_in,
  input  logic [ADDR_W-1:0]              sp_in,
  interrupt_service_controller_if.master mem,
  output logic                           busy,
  output logic                           flush,
  output logic                           pc_load,
  output logic [PC_W-1:0]                pc_out,
  output logic                           flags_load,
  output logic [FLAG_W-1:0]              flags_out,
  output logic                           sp_we,
  output logic [ADDR_W-1:0]              sp_out
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

  logic [3:0]        state_q, state_d;
  logic [3:0]        cnt_q,   cnt_d;
  logic              pend_q,  pend_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [ADDR_W-1:0] s_q,     s_d;

  logic [ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0] sp_c;
  logic [15:0]       wdata_c;
  logic              req_c;

  interrupt_stack_addr #(
    .ADDR_W   (ADDR_W),
    .VEC_ADDR (VEC_ADDR)
  ) u_stack_addr (
    .s_i     (s_q),
    .state_i (state_q),
    .pop_i   (is_pop_state(state_q)),
    .addr_o  (addr_c),
    .sp_o    (sp_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pc_q    <= '0;
      flags_q <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      s_q     <= s_d;
    end
  end

  // pc_q holds the saved PC during the pushes, then is reused to assemble the target PC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    s_d     = s_q;
    case (state_q)
      ST_IDLE: begin
        if (intr_req || pend_q) begin
          pc_d    = pc_in;
          flags_d = flags_in;
          s_d     = sp_in;
          pend_d  = 1'b0;
          cnt_d   = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end else if (rti_req) begin
          s_d     = sp_in;
          state_d = ST_POP_FL;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd0) state_d = ST_PUSH_HI;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_PUSH_HI: if (mem.mem_ack) state_d = ST_PUSH_LO;
      ST_PUSH_LO: if (mem.mem_ack) state_d = ST_PUSH_FL;
      ST_PUSH_FL: if (mem.mem_ack) state_d = ST_VEC_HI;
      ST_VEC_HI: if (mem.mem_ack) begin
        pc_d[PC_W-1 -: 16] = mem.mem_rdata;
        state_d = ST_VEC_LO;
      end
      ST_VEC_LO: if (mem.mem_ack) begin
        pc_d[15:0] = mem.mem_rdata;
        state_d = ST_JUMP;
      end
      ST_POP_FL: if (mem.mem_ack) begin
        flags_d = mem.mem_rdata[FLAG_W-1:0];
        state_d = ST_POP_LO;
      end
      ST_POP_LO: if (mem.mem_ack) begin
        pc_d[15:0] = mem.mem_rdata;
        state_d = ST_POP_HI;
      end
      ST_POP_HI: if (mem.mem_ack) begin
        pc_d[PC_W-1 -: 16] = mem.mem_rdata;
        state_d = ST_RET;
      end
      default: state_d = ST_IDLE;
    endcase
    // A second interrupt while one is pending is absorbed into the same bit.
    if (state_q != ST_IDLE && intr_req) pend_d = 1'b1;
  end

  always_comb begin
    wdata_c = '0;
    case (state_q)
      ST_PUSH_HI: wdata_c = pc_q[PC_W-1 -: 16];
      ST_PUSH_LO: wdata_c = pc_q[15:0];
      ST_PUSH_FL: wdata_c = 16'(flags_q);
      default:    wdata_c = '0;
    endcase
    req_c      = is_mem_state(state_q);
    busy       = (state_q != ST_IDLE);
    flush      = (state_q == ST_DRAIN);
    pc_load    = (state_q == ST_JUMP) || (state_q == ST_RET);
    pc_out     = pc_load ? pc_q : '0;
    flags_load = (state_q == ST_RET);
    flags_out  = flags_load ? flags_q : '0;
    sp_we      = pc_load;
    sp_out     = sp_we ? sp_c : '0;
  end

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = state_q inside {ST_PUSH_HI, ST_PUSH_LO, ST_PUSH_FL};
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;

endmodule

// File: tb/tb_interrupt_service_controller.sv
// Randomized scoreboard bench for interrupt_service_controller with a behavioural CPU/memory model.
module tb_interrupt_service_controller;

  localparam int          D   = 3;
  localparam logic [31:0] VEC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        intr_req = 1'b0, rti_req = 1'b0;
  logic [31:0] pc_reg = '0, sp_reg = '0;
  logic [3:0]  flags_reg = '0;
  logic        busy, flush, pc_load, flags_load, sp_we;
  logic [31:0] pc_out, sp_out;
  logic [3:0]  flags_out;

  interrupt_service_controller_if #(.ADDR_W(32)) mem_if ();

  interrupt_service_controller #(
    .PC_W(32), .ADDR_W(32), .FLAG_W(4), .VEC_ADDR(VEC), .DRAIN_CYC(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .intr_req   (intr_req),
    .rti_req    (rti_req),
    .pc_in      (pc_reg),
    .flags_in   (flags_reg),
    .sp_in      (sp_reg),
    .mem        (mem_if),
    .busy       (busy),
    .flush      (flush),
    .pc_load    (pc_load),
    .pc_out     (pc_out),
    .flags_load (flags_load),
    .flags_out  (flags_out),
    .sp_we      (sp_we),
    .sp_out     (sp_out)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: the real store seen by the DUT, with a programmable number of wait cycles.
  bit [15:0] mem_arr [bit [31:0]];
  int wait_n = 0;
  initial begin
    int wcnt = 0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !mem_if.mem_req) begin
        mem_if.mem_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= wait_n) begin
        mem_if.mem_ack = 1'b1;
        wcnt = 0;
        if (mem_if.mem_we) mem_arr[mem_if.mem_addr] = mem_if.mem_wdata;
        else mem_if.mem_rdata = mem_arr.exists(mem_if.mem_addr) ? mem_arr[mem_if.mem_addr] : 16'h0;
      end else begin
        mem_if.mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Reference model: architectural CPU registers, its own memory image, expected event queue.
  typedef struct {
    bit        is_mem;
    bit        we;
    bit [31:0] addr;
    bit [15:0] wdata;
    bit [31:0] pc;
    bit [3:0]  fl;
    bit        fl_load;
    bit [31:0] sp;
    int        cyc;
    int        busy_n;
    int        flush_n;
  } exp_t;

  exp_t      exp_q[$];
  bit [31:0] m_pc, m_sp;
  bit [3:0]  m_fl;
  bit [15:0] m_mem [bit [31:0]];

  function automatic bit [15:0] mget(bit [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : 16'h0;
  endfunction

  task automatic push_mem(bit we, bit [31:0] a, bit [15:0] d);
    exp_t e = '{default: 0};
    e.is_mem = 1'b1; e.we = we; e.addr = a; e.wdata = d;
    exp_q.push_back(e);
    if (we) m_mem[a] = d;
  endtask

  task automatic predict_entry(int c0, int w);
    bit [31:0] s = m_sp;
    bit [31:0] vec;
    exp_t e = '{default: 0};
    push_mem(1'b1, s,         m_pc[31:16]);
    push_mem(1'b1, s - 32'd1, m_pc[15:0]);
    push_mem(1'b1, s - 32'd2, {12'h0, m_fl});
    push_mem(1'b0, VEC,         16'h0);
    push_mem(1'b0, VEC + 32'd1, 16'h0);
    vec = {mget(VEC), mget(VEC + 32'd1)};
    e.pc = vec; e.sp = s - 32'd3; e.fl_load = 1'b0;
    e.cyc = c0 + D + 6 + 5 * w; e.busy_n = D + 6 + 5 * w; e.flush_n = D;
    exp_q.push_back(e);
    m_pc = vec; m_sp = s - 32'd3;
  endtask

  task automatic predict_rti(int c0, int w);
    bit [31:0] s = m_sp;
    bit [15:0] fw;
    exp_t e = '{default: 0};
    push_mem(1'b0, s + 32'd1, 16'h0);
    push_mem(1'b0, s + 32'd2, 16'h0);
    push_mem(1'b0, s + 32'd3, 16'h0);
    fw = mget(s + 32'd1);
    e.pc = {mget(s + 32'd3), mget(s + 32'd2)}; e.fl = fw[3:0]; e.fl_load = 1'b1;
    e.sp = s + 32'd3; e.cyc = c0 + 4 + 3 * w; e.busy_n = 4 + 3 * w; e.flush_n = 0;
    exp_q.push_back(e);
    m_pc = e.pc; m_fl = e.fl; m_sp = e.sp;
  endtask

  // Monitor: compares every presented memory request and every PC load against the queue front.
  int   busy_n = 0, flush_n = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      busy_n = 0;
      flush_n = 0;
    end else begin
      busy_n  += int'(busy);
      flush_n += int'(flush);
      if (mem_if.mem_req) begin
        if (exp_q.size() == 0 || !exp_q[0].is_mem) chk("no_mem_req_expected", mem_if.mem_req, 32'd0);
        else begin
          chk("mem_addr", mem_if.mem_addr, exp_q[0].addr);
          chk("mem_we", mem_if.mem_we, 32'(exp_q[0].we));
          if (exp_q[0].we) chk("mem_wdata", mem_if.mem_wdata, 32'(exp_q[0].wdata));
          if (mem_if.mem_ack) void'(exp_q.pop_front());
        end
      end
      if (pc_load) begin
        if (exp_q.size() == 0 || exp_q[0].is_mem) chk("no_pc_load_expected", pc_load, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("pc_out", pc_out, mon_e.pc);
          chk("sp_we", sp_we, 32'd1);
          chk("sp_out", sp_out, mon_e.sp);
          chk("flags_load", flags_load, 32'(mon_e.fl_load));
          if (mon_e.fl_load) chk("flags_out", flags_out, 32'(mon_e.fl));
          chk("load_cycle", cyc, mon_e.cyc);
          chk("busy_cycles", busy_n, mon_e.busy_n);
          chk("flush_cycles", flush_n, mon_e.flush_n);
        end
        busy_n = 0;
        flush_n = 0;
        pc_reg = pc_out;
        if (sp_we) sp_reg = sp_out;
        if (flags_load) flags_reg = flags_out;
      end
    end
  end

  task automatic set_cpu(bit [31:0] pc, bit [3:0] fl, bit [31:0] sp);
    pc_reg = pc; flags_reg = fl; sp_reg = sp;
    m_pc = pc; m_fl = fl; m_sp = sp;
  endtask

  task automatic poke(bit [31:0] a, bit [15:0] d);
    mem_arr[a] = d;
    m_mem[a] = d;
  endtask

  task automatic do_entry();
    int c0 = cyc;
    intr_req = 1'b1;
    predict_entry(c0, wait_n);
    @(negedge clk);
    intr_req = 1'b0;
  endtask

  task automatic do_rti();
    int c0 = cyc;
    rti_req = 1'b1;
    predict_rti(c0, wait_n);
    @(negedge clk);
    rti_req = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: %0d expected events outstanding after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_mem(bit we, bit [31:0] a, int budget);
    int n = 0;
    while (!(mem_if.mem_req && mem_if.mem_we == we && mem_if.mem_addr == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL wait_mem: no request to 0x%0h (we=%0d) within %0d cycles", a, we, budget);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_flush"}, flush, 32'd0);
    chk({tag, "_mem_req"}, mem_if.mem_req, 32'd0);
    chk({tag, "_mem_we"}, mem_if.mem_we, 32'd0);
    chk({tag, "_mem_addr"}, mem_if.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_if.mem_wdata), 32'd0);
    chk({tag, "_pc_load"}, pc_load, 32'd0);
    chk({tag, "_pc_out"}, pc_out, 32'd0);
    chk({tag, "_flags_load"}, flags_load, 32'd0);
    chk({tag, "_flags_out"}, 32'(flags_out), 32'd0);
    chk({tag, "_sp_we"}, sp_we, 32'd0);
    chk({tag, "_sp_out"}, sp_out, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit [31:0] spv, save_pc, save_sp;
    bit [3:0]  save_fl;
    int        c0;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Zero-wait entry from the worked example.
    wait_n = 0;
    poke(VEC, 16'h0000);
    poke(VEC + 32'd1, 16'h0200);
    set_cpu(32'h0001_2345, 4'hA, 32'h0000_0FFF);
    @(negedge clk);
    do_entry();
    wait_done(60);

    // RTI straight back out of that handler.
    do_rti();
    wait_done(60);

    // Two wait cycles on every access.
    wait_n = 2;
    set_cpu(32'h8765_4321, 4'h3, 32'h0000_4000);
    @(negedge clk);
    do_entry();
    wait_done(100);
    do_rti();
    wait_done(100);

    // Collision with RTI, then a pending interrupt and an absorbed duplicate.
    wait_n = 0;
    poke(VEC, 16'h0000);
    poke(VEC + 32'd1, 16'h4000);
    set_cpu(32'hCAFE_0100, 4'h5, 32'h0000_2000);
    @(negedge clk);
    c0 = cyc;
    intr_req = 1'b1;
    rti_req  = 1'b1;
    predict_entry(c0, 0);
    @(negedge clk);
    intr_req = 1'b0;
    rti_req  = 1'b0;
    wait_mem(1'b1, 32'h0000_1FFF, 30);
    intr_req = 1'b1;
    predict_entry(c0 + D + 7, 0);
    @(negedge clk);
    intr_req = 1'b0;
    wait_mem(1'b0, VEC, 30);
    intr_req = 1'b1;
    @(negedge clk);
    intr_req = 1'b0;
    wait_done(150);
    repeat (20) @(negedge clk);

    // Stack pointer wrapping through zero.
    set_cpu(32'h1357_9BDF, 4'hC, 32'h0000_0001);
    @(negedge clk);
    do_entry();
    wait_done(60);

    // Randomized entries and returns.
    for (int i = 0; i < 24; i++) begin
      wait_n = $urandom_range(0, 2);
      spv = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        poke(VEC, 16'($urandom));
        poke(VEC + 32'd1, 16'($urandom));
        set_cpu($urandom, 4'($urandom), spv);
        @(negedge clk);
        do_entry();
      end else begin
        poke(spv + 32'd1, 16'($urandom));
        poke(spv + 32'd2, 16'($urandom));
        poke(spv + 32'd3, 16'($urandom));
        set_cpu($urandom, 4'($urandom), spv);
        @(negedge clk);
        do_rti();
      end
      wait_done(100);
    end

    // Reset while fetching the vector: no load may follow, then a clean entry.
    wait_n = 1;
    poke(VEC, 16'h0000);
    poke(VEC + 32'd1, 16'h0300);
    set_cpu(32'h0000_5555, 4'h6, 32'h0000_8000);
    save_pc = m_pc; save_sp = m_sp; save_fl = m_fl;
    @(negedge clk);
    do_entry();
    wait_mem(1'b0, VEC, 60);
    #1 rst = 1'b1;
    #1 check_zero("midreset");
    exp_q.delete();
    m_pc = save_pc; m_sp = save_sp; m_fl = save_fl;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("pc_kept_after_reset", pc_reg, save_pc);
    chk("sp_kept_after_reset", sp_reg, save_sp);
    do_entry();
    wait_done(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
